// File: rtl/alu_pkg.sv
// Shared definitions for the C-bus ALU stage: default width, op codes and
// the multiplier FSM state encoding.
package alu_pkg;

    // Default operand / bus width.
    localparam int DEFAULT_DATA_W = 24;

    // 3-bit operation codes, sampled together with start.
    localparam logic [2:0] OP_PASSB = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_INC   = 3'b011;
    localparam logic [2:0] OP_SHR   = 3'b100;
    localparam logic [2:0] OP_SHL   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_CLR   = 3'b111;

    // Iterative multiplier states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } mul_state_t;

endpackage

// File: rtl/alu_cbus_if.sv
// Operand / result bus bundle between the control unit (master) and the
// ALU stage (slave).
interface alu_cbus_if
    import alu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) ();

    logic [DATA_W-1:0] a_bus;
    logic [DATA_W-1:0] b_bus;
    logic [2:0]        alu_op;
    logic              start;
    logic [DATA_W-1:0] c_bus;
    logic              done;
    logic              busy;
    logic              z_flag;
    logic              c_flag;

    // Control unit side: issues operands and requests, observes results.
    modport master (
        output a_bus, b_bus, alu_op, start,
        input  c_bus, done, busy, z_flag, c_flag
    );

    // ALU side: consumes operands, drives the C bus and status.
    modport slave (
        input  a_bus, b_bus, alu_op, start,
        output c_bus, done, busy, z_flag, c_flag
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per clock, DATA_W
// clocks per multiply. done is a combinational strobe that is high in the
// cycle whose closing edge completes the multiply; product carries the
// final 2*DATA_W value during that same cycle so the parent can register
// it on that edge without an extra stage of latency.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                busy,
    output logic                done,
    output logic [2*DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    mul_state_t          state_q, state_d;
    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic [2*DATA_W-1:0] acc_step;

    // Accumulator value after this cycle's conditional add.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : {(2*DATA_W){1'b0}});
    assign product  = acc_step;
    assign busy     = busy_q;

    // Next-state logic: capture operands on start, then one shift-add per edge.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d  = {{DATA_W{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_MUL;
                end
            end
            ST_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    done    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_cbus.sv
// ALU stage feeding the general-purpose registers over the C bus.
// Single-cycle ops complete on the accept edge; MUL runs through the
// iterative multiplier and completes DATA_W edges later.
// Optional build macro SATURATE_EN: clamp ADD/INC/SUB/MUL results on
// overflow/underflow instead of wrapping (c_flag still reports it).
module alu_cbus
    import alu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_cbus_if.slave  bus
);

    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [2:0]          op;
    logic                accept;
    logic                mul_start;
    logic                mul_busy;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_product;
    logic                mul_hi_nz;
    logic [DATA_W-1:0]   mul_res;

    logic [DATA_W:0]     add_full;
    logic [DATA_W:0]     sub_full;
    logic [DATA_W:0]     inc_full;
    logic [DATA_W-1:0]   op_res;
    logic                op_c;

    logic [DATA_W-1:0]   c_bus_q, c_bus_d;
    logic                z_q, z_d;
    logic                cf_q, cf_d;
    logic                done_q, done_d;

    assign a  = bus.a_bus;
    assign b  = bus.b_bus;
    assign op = bus.alu_op;

    // Requests while a multiply is in flight are dropped, not queued.
    assign accept    = bus.start && !mul_busy;
    assign mul_start = accept && (op == OP_MUL);

    alu_mul_seq #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Extra top bit on each carries the carry / borrow out.
    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} - {1'b0, b};
    assign inc_full = {1'b0, a} + (DATA_W + 1)'(1);

    // Multiply result: overflow is any nonzero bit in the upper half.
    always_comb begin
        mul_hi_nz = |mul_product[2*DATA_W-1:DATA_W];
        mul_res   = mul_product[DATA_W-1:0];
`ifdef SATURATE_EN
        if (mul_hi_nz) begin
            mul_res = '1;
        end
`endif
    end

    // Single-cycle op result and carry/borrow/shift-out flag.
    always_comb begin
        op_res = '0;
        op_c   = 1'b0;
        unique case (op)
            OP_PASSB: begin
                op_res = b;
            end
            OP_ADD: begin
                op_res = add_full[DATA_W-1:0];
                op_c   = add_full[DATA_W];
`ifdef SATURATE_EN
                if (op_c) op_res = '1;
`endif
            end
            OP_SUB: begin
                op_res = sub_full[DATA_W-1:0];
                op_c   = sub_full[DATA_W];
`ifdef SATURATE_EN
                if (op_c) op_res = '0;
`endif
            end
            OP_INC: begin
                op_res = inc_full[DATA_W-1:0];
                op_c   = inc_full[DATA_W];
`ifdef SATURATE_EN
                if (op_c) op_res = '1;
`endif
            end
            OP_SHR: begin
                op_res = {1'b0, a[DATA_W-1:1]};
                op_c   = a[0];
            end
            OP_SHL: begin
                op_res = {a[DATA_W-2:0], 1'b0};
                op_c   = a[DATA_W-1];
            end
            OP_MUL: begin
                // Completed through the multiplier, not here.
                op_res = '0;
            end
            OP_CLR: begin
                op_res = '0;
            end
            default: begin
                op_res = '0;
            end
        endcase
    end

    // Result register update: multiplier completion or an accepted single-cycle op.
    always_comb begin
        c_bus_d = c_bus_q;
        z_d     = z_q;
        cf_d    = cf_q;
        done_d  = 1'b0;
        if (mul_done) begin
            c_bus_d = mul_res;
            z_d     = (mul_res == '0);
            cf_d    = mul_hi_nz;
            done_d  = 1'b1;
        end else if (accept && (op != OP_MUL)) begin
            c_bus_d = op_res;
            z_d     = (op_res == '0);
            cf_d    = op_c;
            done_d  = 1'b1;
        end
    end

    // C bus, flags and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_bus_q <= '0;
            z_q     <= 1'b0;
            cf_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            c_bus_q <= c_bus_d;
            z_q     <= z_d;
            cf_q    <= cf_d;
            done_q  <= done_d;
        end
    end

    assign bus.c_bus  = c_bus_q;
    assign bus.z_flag = z_q;
    assign bus.c_flag = cf_q;
    assign bus.done   = done_q;
    assign bus.busy   = mul_busy;

endmodule

// File: tb/tb_alu_cbus.sv
// Self-checking bench for alu_cbus: directed vector table, hand-written
// back-to-back and mid-multiply reset sequences, then random ops checked
// against an arithmetic reference model. Honours SATURATE_EN.
module tb_alu_cbus;
    import alu_pkg::*;

    localparam int W = 24;
    localparam int MAX_WAIT = 40;

    logic clk;
    logic rst_n;

    alu_cbus_if #(.DATA_W(W)) bus_if ();

    alu_cbus #(.DATA_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic       z;
        logic       c;
        bit         interfere;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [2:0] op,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] res, input logic z,
                                input logic c, input bit interfere);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b;
        v.res = res; v.z = z; v.c = c; v.interfere = interfere;
        return v;
    endfunction

    // Reference: plain unsigned arithmetic on wide integers. Returns {z, c, result}.
    function automatic logic [W+1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint unsigned ua  = 64'(a);
        longint unsigned ub  = 64'(b);
        longint unsigned lim = 64'd1 << W;
        longint unsigned full = 0;
        longint unsigned r = 0;
        logic [W-1:0] rr;
        bit c = 1'b0;
        case (op)
            OP_PASSB: r = ub;
            OP_ADD: begin
                full = ua + ub; c = (full >= lim); r = full % lim;
`ifdef SATURATE_EN
                if (c) r = lim - 1;
`endif
            end
            OP_SUB: begin
                c = (ua < ub); r = c ? (lim + ua - ub) : (ua - ub);
`ifdef SATURATE_EN
                if (c) r = 0;
`endif
            end
            OP_INC: begin
                full = ua + 1; c = (full >= lim); r = full % lim;
`ifdef SATURATE_EN
                if (c) r = lim - 1;
`endif
            end
            OP_SHR: begin
                r = ua / 2; c = ((ua % 2) == 1);
            end
            OP_SHL: begin
                full = ua * 2; c = (full >= lim); r = full % lim;
            end
            OP_MUL: begin
                full = ua * ub; c = (full >= lim); r = full % lim;
`ifdef SATURATE_EN
                if (c) r = lim - 1;
`endif
            end
            default: r = 0;
        endcase
        rr = r[W-1:0];
        return {(r == 0), c, rr};
    endfunction

    // Issue one op and follow it to its done pulse, checking latency,
    // result, flags, C-bus hold while waiting, and the single-cycle done pulse.
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input logic exp_z,
                          input logic exp_c, input bit interfere);
        int edges;
        int exp_lat;
        bit hold_ok;
        logic [W-1:0] prev_c;
        exp_lat = (op == OP_MUL) ? W + 1 : 1;
        hold_ok = 1'b1;
        @(negedge clk);
        prev_c         = bus_if.c_bus;
        bus_if.a_bus   = a;
        bus_if.b_bus   = b;
        bus_if.alu_op  = op;
        bus_if.start   = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.a_bus = W'($urandom);
        bus_if.b_bus = W'($urandom);
        edges = 1;
        while (!bus_if.done && edges < MAX_WAIT) begin
            if (bus_if.c_bus !== prev_c) hold_ok = 1'b0;
            bus_if.start  = (interfere && edges == 5);
            bus_if.alu_op = OP_ADD;
            @(posedge clk);
            #1;
            edges++;
        end
        bus_if.start = 1'b0;
        $display("%s op=%0d a=%06h b=%06h -> c_bus=%06h z=%0b c=%0b latency=%0d",
                 name, op, a, b, bus_if.c_bus, bus_if.z_flag, bus_if.c_flag, edges);
        chk({name, ".done"}, 48'(bus_if.done), 48'(1));
        chk({name, ".latency"}, 48'(edges), 48'(exp_lat));
        chk({name, ".c_bus"}, 48'(bus_if.c_bus), 48'(exp_res));
        chk({name, ".flags"}, 48'({bus_if.z_flag, bus_if.c_flag}), 48'({exp_z, exp_c}));
        if (op == OP_MUL) chk({name, ".hold"}, 48'(hold_ok), 48'(1));
        @(posedge clk);
        #1;
        chk({name, ".pulse"}, 48'({bus_if.done, bus_if.busy}), 48'(0));
    endtask

    initial begin
        logic [W+1:0] m;
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;
        int dones;

        rst_n         = 1'b0;
        bus_if.a_bus  = '0;
        bus_if.b_bus  = '0;
        bus_if.alu_op = OP_PASSB;
        bus_if.start  = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 48'({bus_if.c_bus, bus_if.done, bus_if.busy,
                                  bus_if.z_flag, bus_if.c_flag}), 48'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        vecs[0]  = mk("add_basic", OP_ADD, 24'h00000F, 24'h000001, 24'h000010, 1'b0, 1'b0, 1'b0);
`ifdef SATURATE_EN
        vecs[1]  = mk("add_ovf",   OP_ADD, 24'hFFFFFF, 24'h000002, 24'hFFFFFF, 1'b0, 1'b1, 1'b0);
        vecs[3]  = mk("sub_brw",   OP_SUB, 24'h000003, 24'h000005, 24'h000000, 1'b1, 1'b1, 1'b0);
        vecs[5]  = mk("mul_ovf",   OP_MUL, 24'h001000, 24'h001000, 24'hFFFFFF, 1'b0, 1'b1, 1'b0);
        vecs[7]  = mk("inc_ovf",   OP_INC, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 1'b0, 1'b1, 1'b0);
        vecs[12] = mk("mul_max",   OP_MUL, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, 1'b1);
`else
        vecs[1]  = mk("add_ovf",   OP_ADD, 24'hFFFFFF, 24'h000002, 24'h000001, 1'b0, 1'b1, 1'b0);
        vecs[3]  = mk("sub_brw",   OP_SUB, 24'h000003, 24'h000005, 24'hFFFFFE, 1'b0, 1'b1, 1'b0);
        vecs[5]  = mk("mul_ovf",   OP_MUL, 24'h001000, 24'h001000, 24'h000000, 1'b1, 1'b1, 1'b0);
        vecs[7]  = mk("inc_ovf",   OP_INC, 24'hFFFFFF, 24'h000000, 24'h000000, 1'b1, 1'b1, 1'b0);
        vecs[12] = mk("mul_max",   OP_MUL, 24'hFFFFFF, 24'hFFFFFF, 24'h000001, 1'b0, 1'b1, 1'b1);
`endif
        vecs[2]  = mk("sub_zero",  OP_SUB, 24'h000005, 24'h000005, 24'h000000, 1'b1, 1'b0, 1'b0);
        vecs[4]  = mk("mul_basic", OP_MUL, 24'h000123, 24'h000010, 24'h001230, 1'b0, 1'b0, 1'b1);
        vecs[6]  = mk("passb",     OP_PASSB, 24'h000001, 24'hABCDEF, 24'hABCDEF, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk("shr",       OP_SHR, 24'h000007, 24'h000000, 24'h000003, 1'b0, 1'b1, 1'b0);
        vecs[9]  = mk("shl",       OP_SHL, 24'h800001, 24'h000000, 24'h000002, 1'b0, 1'b1, 1'b0);
        vecs[10] = mk("clr",       OP_CLR, 24'h000005, 24'h000009, 24'h000000, 1'b1, 1'b0, 1'b0);
        vecs[11] = mk("mul_zero",  OP_MUL, 24'h000000, 24'h123456, 24'h000000, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].interfere);
        end

        // Back-to-back: INC then SHR on consecutive cycles, done high both cycles.
        @(negedge clk);
        bus_if.a_bus  = 24'h000007;
        bus_if.alu_op = OP_INC;
        bus_if.start  = 1'b1;
        @(posedge clk);
        #1;
        $display("b2b_inc -> c_bus=%06h c=%0b done=%0b", bus_if.c_bus, bus_if.c_flag, bus_if.done);
        chk("b2b_inc", 48'({bus_if.done, bus_if.c_flag, bus_if.c_bus}), 48'({1'b1, 1'b0, 24'h000008}));
        bus_if.alu_op = OP_SHR;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        $display("b2b_shr -> c_bus=%06h c=%0b done=%0b", bus_if.c_bus, bus_if.c_flag, bus_if.done);
        chk("b2b_shr", 48'({bus_if.done, bus_if.c_flag, bus_if.c_bus}), 48'({1'b1, 1'b1, 24'h000003}));
        @(posedge clk);
        #1;
        chk("b2b_idle_hold", 48'({bus_if.done, bus_if.c_bus}), 48'({1'b0, 24'h000003}));

        // Reset ten edges into a multiply: immediate clear, no done afterwards.
        @(negedge clk);
        bus_if.a_bus  = 24'h123456;
        bus_if.b_bus  = 24'h654321;
        bus_if.alu_op = OP_MUL;
        bus_if.start  = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_mul_busy", 48'(bus_if.busy), 48'(1));
        rst_n = 1'b0;
        #1;
        $display("mid_mul_reset -> c_bus=%06h busy=%0b done=%0b", bus_if.c_bus, bus_if.busy, bus_if.done);
        chk("mid_mul_reset", 48'({bus_if.c_bus, bus_if.done, bus_if.busy,
                                  bus_if.z_flag, bus_if.c_flag}), 48'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.done) dones++;
        end
        chk("post_reset_no_done", 48'(dones), 48'(0));
        chk("post_reset_idle", 48'({bus_if.c_bus, bus_if.busy}), 48'(0));

        // Random ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = W'($urandom);
            rb  = W'($urandom);
            if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 255));
            m = model(rop, ra, rb);
            run_op($sformatf("rand%0d", i), rop, ra, rb, m[W-1:0], m[W+1], m[W],
                   bit'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
